instr_cache_fill_responder: RTL
===============================

// Module: instr_cache_fill_responder
// PURPOSE
//  L2-side responder for the multi-cycle instruction-cache line fill. On an I-cache miss it fetches
//  the 64-bit-aligned line from the backing memory, buffers the whole line, then streams it as
//  B/8 back-to-back 64-bit beats on rep_word_o with rep_enable_o high for exactly B/8 cycles.
//  Sits between the I-cache sets (consumers of RepWord/rep_enable_i) and the L2/memory read port.
// PARAMETERS
//  B          64  line size in bytes (power of 2, >=16); NumBeats = B/8
//  AddrWidth  32  byte address width
// PORTS
//  clk_i              in   1          clock, all state on rising edge
//  reset_ni           in   1          asynchronous, active-low reset
//  miss_i             in   1          OR of CacheSetMiss of active set (cache lookup missed)
//  miss_addr_i        in   AddrWidth  fetch address of the missing instruction
//  rep_enable_o       out  1          beat valid to cache; high NumBeats consecutive cycles
//  rep_word_o         out  64         current beat (low word = lower address)
//  fill_busy_o        out  1          high from miss capture until return to IDLE (stall fetch)
//  mem_req_valid_o    out  1          memory read request valid
//  mem_req_ready_i    in   1          memory accepts request
//  mem_req_addr_o     out  AddrWidth  8-byte-aligned beat address
//  mem_rdata_valid_i  in   1          read data valid (in request order, no backpressure)
//  mem_rdata_i        in   64         read data
// BEHAVIOUR
//  Reset (async, reset_ni=0): state=IDLE, all outputs 0, req/resp counters 0, buffer contents don't-care.
//  States: IDLE -> REQ/COLLECT -> STREAM -> DONE -> IDLE.
//  IDLE: miss_i=1 captures line_base={miss_addr_i[AW-1:log2B], log2B'b0}; next cycle enters REQ,
//    fill_busy_o=1. miss_i is sampled only in IDLE.
//  REQ/COLLECT (single state, two counters): mem_req_valid_o=1 while req_cnt<NumBeats;
//    mem_req_addr_o=line_base+8*req_cnt; req_cnt++ on valid&&ready. Independently, each
//    mem_rdata_valid_i writes mem_rdata_i into buf[resp_cnt], resp_cnt++. Responses may arrive
//    the cycle after acceptance or later, and may overlap further requests. mem_rdata_valid_i
//    outside this state is ignored.
//  Transition to STREAM on the cycle resp_cnt reaches NumBeats (last beat written that edge).
//  STREAM: rep_enable_o=1, rep_word_o=buf[beat_cnt], beat_cnt 0..NumBeats-1, one beat/cycle,
//    no gaps, no backpressure (cache counter free-runs). beat_cnt==NumBeats-1 -> DONE.
//  DONE: one cycle, rep_enable_o=0, fill_busy_o=1; covers the cycle where the cache tag write
//    lands so a stale miss_i cannot re-trigger. Then IDLE, fill_busy_o=0.
//  rep_word_o is 0 whenever rep_enable_o=0 (no stale data on the bus).
//  Latency miss_i->first beat: 1 + memory round trip for NumBeats beats; min 1+1+NumBeats cycles
//    with single-cycle memory.
//  Counters are $clog2(NumBeats)+1 bits; no wrap within a line; cleared on entry to REQ.
//  Address arithmetic: line_base never carries across a line boundary; low 3 addr bits always 0.
//  Reset mid-operation: immediate return to IDLE, rep_enable_o drops asynchronously; partial
//    line discarded; in-flight memory responses after reset deassertion are ignored (IDLE).
//  mem_rdata_valid_i with resp_cnt==NumBeats cannot occur (requests bounded); assert in sim.
// STRUCTURE
//  Package instr_fill_pkg: fill_state_t enum {IDLE, REQ, STREAM, DONE}; function
//    num_beats(B)=B/8; localparam BEAT_BYTES=8.
//  Sub-module fill_line_buffer (NumBeats x 64 distributed RAM, 1 sync write port,
//    1 async read port); FSM, counters and address gen in this module.
// TESTING
//  1 Reset: hold reset_ni=0 with miss_i=1 -> all outputs 0; release -> capture, fill_busy_o=1 next cycle.
//  2 B=64, 1-cycle memory, miss_addr_i=0x0000_1234 -> reqs 0x1200,0x1208..0x1238 (8),
//    rep_enable_o high 8 consecutive cycles, beats = mem words in order, DONE 1 cycle, busy low after.
//  3 Random mem_req_ready_i/latency 1-5 cycles -> identical 8-beat contiguous stream, no gap, order kept.
//  4 miss_i held high through DONE -> exactly one fill; new miss 0x2040 accepted only after IDLE.
//  5 reset_ni pulsed low during beat 3 of STREAM -> rep_enable_o 0 immediately; stray mem
//    responses after release ignored; next miss fills cleanly.
//  6 B=16 -> 2 requests, 2-beat stream; rep_word_o=0 outside stream.

Source files
------------

// File: rtl/instr_fill_pkg.sv
// ----------------------------------------------------------------------------
// instr_fill_pkg
//   Shared types and constants for the instruction-cache line-fill responder.
//   - fill_state_t : responder FSM states (IDLE, REQ, STREAM, DONE)
//   - BEAT_BYTES   : bytes carried by one 64-bit beat
//   - num_beats()  : beats per line for a given line size in bytes
// ----------------------------------------------------------------------------
package instr_fill_pkg;

   localparam int BEAT_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } fill_state_t;

   function automatic int num_beats(input int line_bytes);
      return line_bytes / BEAT_BYTES;
   endfunction

endpackage

// File: rtl/fill_line_buffer.sv
// ----------------------------------------------------------------------------
// fill_line_buffer
//   Holds one cache line while it is being collected from memory, so the line
//   can then be replayed to the cache as an unbroken burst. One synchronous
//   write port, one asynchronous read port.
//   Ports:
//     clk_i    in   clock
//     wr_en    in   write strobe
//     wr_idx   in   beat slot to write
//     wr_data  in   beat data to write
//     rd_idx   in   beat slot to read
//     rd_data  out  beat data at rd_idx (combinational)
// ----------------------------------------------------------------------------
module fill_line_buffer #(
   parameter  int Depth = 8,
   parameter  int Width = 64,
   localparam int IdxW  = $clog2(Depth)
) (
   input  logic             clk_i,
   input  logic             wr_en,
   input  logic [IdxW-1:0]  wr_idx,
   input  logic [Width-1:0] wr_data,
   input  logic [IdxW-1:0]  rd_idx,
   output logic [Width-1:0] rd_data
);

   logic [Width-1:0] mem_q [Depth];

   // NOTE: the storage array has no reset; every slot is written before it is
   // read within a fill, so resetting it would only cost logic.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/instr_cache_fill_responder.sv
// ----------------------------------------------------------------------------
// instr_cache_fill_responder
//   L2-side responder for instruction-cache line fills. A miss captures the
//   line base address, the line is fetched from memory as 64-bit beats
//   (requests and responses may overlap), buffered, and then replayed to the
//   cache as B/8 back-to-back beats with rep_enable_o high.
//   Ports:
//     clk_i              in   clock
//     reset_ni           in   asynchronous active-low reset
//     miss_i             in   cache lookup missed (sampled only when idle)
//     miss_addr_i        in   fetch address of the missing instruction
//     rep_enable_o       out  beat valid to the cache
//     rep_word_o         out  current beat, zero when rep_enable_o is low
//     fill_busy_o        out  fill in progress, stalls fetch
//     mem_req_valid_o    out  memory read request valid
//     mem_req_ready_i    in   memory accepts the request
//     mem_req_addr_o     out  8-byte-aligned beat address
//     mem_rdata_valid_i  in   read data valid, in request order
//     mem_rdata_i        in   read data
// ----------------------------------------------------------------------------
module instr_cache_fill_responder
   import instr_fill_pkg::*;
#(
   parameter int B         = 64,
   parameter int AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 miss_i,
   input  logic [AddrWidth-1:0] miss_addr_i,
   output logic                 rep_enable_o,
   output logic [63:0]          rep_word_o,
   output logic                 fill_busy_o,
   output logic                 mem_req_valid_o,
   input  logic                 mem_req_ready_i,
   output logic [AddrWidth-1:0] mem_req_addr_o,
   input  logic                 mem_rdata_valid_i,
   input  logic [63:0]          mem_rdata_i
);

   localparam int NumBeats  = num_beats(B);
   localparam int LineShift = $clog2(B);
   localparam int BeatShift = $clog2(BEAT_BYTES);
   localparam int IdxW      = $clog2(NumBeats);
   // One extra bit so a counter can hold NumBeats itself ("all issued").
   localparam int CntW      = IdxW + 1;

   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(NumBeats);
   localparam logic [CntW-1:0] CntLast = CntW'(NumBeats - 1);

   fill_state_t           state_q, state_d;
   logic [AddrWidth-1:0]  line_base_q;
   logic [CntW-1:0]       req_cnt_q;
   logic [CntW-1:0]       resp_cnt_q;
   logic [CntW-1:0]       beat_cnt_q;
   logic                  req_fire;
   logic                  resp_write;
   logic [63:0]           buf_rdata;
   logic [LineShift-1:0]  addr_lo_unused;

   // Offset bits within the line never reach the address path.
   assign addr_lo_unused = miss_addr_i[LineShift-1:0];

   assign req_fire   = mem_req_valid_o && mem_req_ready_i;
   // Responses are only meaningful while collecting; strays elsewhere drop.
   assign resp_write = (state_q == REQ) && mem_rdata_valid_i;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (miss_i) state_d = REQ;
         // Leave on the edge that writes the final beat into the buffer.
         REQ:     if (resp_write && (resp_cnt_q == CntLast)) state_d = STREAM;
         STREAM:  if (beat_cnt_q == CntLast) state_d = DONE;
         // One guard cycle so a miss still asserted while the tag write
         // lands cannot start a second fill of the same line.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Line base and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         line_base_q <= '0;
         req_cnt_q   <= '0;
         resp_cnt_q  <= '0;
         beat_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_i) begin
                  line_base_q <= {miss_addr_i[AddrWidth-1:LineShift], {LineShift{1'b0}}};
                  req_cnt_q   <= '0;
                  resp_cnt_q  <= '0;
                  beat_cnt_q  <= '0;
               end
            end
            REQ: begin
               if (req_fire) req_cnt_q <= req_cnt_q + CntOne;
               if (resp_write) begin
                  // Requests are capped at NumBeats, so a response with the
                  // buffer already full means the memory side misbehaved.
                  assert (resp_cnt_q < CntFull);
                  resp_cnt_q <= resp_cnt_q + CntOne;
               end
            end
            STREAM:  beat_cnt_q <= beat_cnt_q + CntOne;
            default: ;
         endcase
      end
   end

   fill_line_buffer #(
      .Depth (NumBeats),
      .Width (64)
   ) u_line_buffer (
      .clk_i   (clk_i),
      .wr_en   (resp_write),
      .wr_idx  (resp_cnt_q[IdxW-1:0]),
      .wr_data (mem_rdata_i),
      .rd_idx  (beat_cnt_q[IdxW-1:0]),
      .rd_data (buf_rdata)
   );

   // ---------------------------------------------------------------------
   // Outputs: decoded from the registered state only, so reset clears them
   // asynchronously along with state_q.
   // ---------------------------------------------------------------------
   always_comb begin
      rep_enable_o    = 1'b0;
      rep_word_o      = '0;
      fill_busy_o     = 1'b1;
      mem_req_valid_o = 1'b0;
      mem_req_addr_o  = '0;
      case (state_q)
         IDLE: fill_busy_o = 1'b0;
         REQ: begin
            if (req_cnt_q < CntFull) begin
               mem_req_valid_o = 1'b1;
               // Offset stays below B, so the add never carries out of the line.
               mem_req_addr_o  = line_base_q + (AddrWidth'(req_cnt_q) << BeatShift);
            end
         end
         STREAM: begin
            rep_enable_o = 1'b1;
            rep_word_o   = buf_rdata;
         end
         default: ;
      endcase
   end

endmodule
